// File: rtl/r2000_muldiv_iter.sv
// r2000_muldiv_iter: iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, BPC result bits per CALC cycle,
// followed by one FIX cycle that applies signs and writes HI/LO.
// Optional feature macro: MULDIV_MADD_EN (multiply-accumulate into {HI,LO}).
module r2000_muldiv_iter #(
  parameter int DW  = 32,
  parameter int BPC = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] operand1_i,
  input  logic [DW-1:0] operand2_i,
  input  logic          sign_i,
  input  logic          mult_div_i,
  input  logic          start_i,
  input  logic          acc_i,
  input  logic          sub_i,
  input  logic [DW-1:0] datain_i,
  input  logic          hiw_i,
  input  logic          low_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          ready_o,
  output logic          busy_o,
  output logic          dbz_o
);

  localparam int N  = DW / BPC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] op_b_reg;      // multiplicand (mult) or divisor magnitude (div)
  logic [DW:0]   hi_work_reg;   // upper partial product / partial remainder
  logic [DW-1:0] lo_work_reg;   // multiplier shifting out / quotient shifting in
  logic          mult_reg;
  logic          neg_res_reg;   // product or quotient must be negated
  logic          neg_rem_reg;   // remainder must be negated
  logic          div_zero_reg;
  logic [DW-1:0] hi_reg;
  logic [DW-1:0] lo_reg;
  logic          dbz_reg;
`ifdef MULDIV_MADD_EN
  logic          acc_reg;
  logic          sub_reg;
`else
  logic          unused_madd;
  assign unused_madd = ^{acc_i, sub_i};
`endif

  // Operand magnitudes and divide-by-zero detection at start time
  logic [DW-1:0] mag1;
  logic [DW-1:0] mag2;
  logic          start_dbz;
  assign mag1      = (sign_i && operand1_i[DW-1]) ? -operand1_i : operand1_i;
  assign mag2      = (sign_i && operand2_i[DW-1]) ? -operand2_i : operand2_i;
  assign start_dbz = !mult_div_i && (operand2_i == '0);

  // One iteration of shift-add multiply (BPC multiplier bits) and restoring divide
  logic [DW+BPC-1:0] mul_addend;
  logic [DW+BPC-1:0] mul_sum;
  logic [DW:0]       div_rem;
  logic [DW:0]       div_shift;
  logic [DW-1:0]     div_quo;
  logic [DW:0]       hi_work_next;
  logic [DW-1:0]     lo_work_next;
  always_comb begin
    mul_addend = '0;
    for (int j = 0; j < BPC; j++) begin
      if (lo_work_reg[j])
        mul_addend = mul_addend + ({{BPC{1'b0}}, op_b_reg} << j);
    end
    mul_sum = {{BPC{1'b0}}, hi_work_reg[DW-1:0]} + mul_addend;

    div_rem   = hi_work_reg;
    div_quo   = lo_work_reg;
    div_shift = '0;
    for (int j = 0; j < BPC; j++) begin
      div_shift = {div_rem[DW-1:0], div_quo[DW-1]};
      div_quo   = {div_quo[DW-2:0], 1'b0};
      if (div_shift >= {1'b0, op_b_reg}) begin
        div_rem    = div_shift - {1'b0, op_b_reg};
        div_quo[0] = 1'b1;
      end else begin
        div_rem = div_shift;
      end
    end

    if (mult_reg) begin
      hi_work_next = {1'b0, mul_sum[DW+BPC-1:BPC]};
      lo_work_next = {mul_sum[BPC-1:0], lo_work_reg[DW-1:BPC]};
    end else begin
      hi_work_next = div_rem;
      lo_work_next = div_quo;
    end
  end

  // Sign fix-up, optional accumulate, and zero-divisor override for the FIX cycle
  logic [2*DW-1:0] prod_mag;
  logic [2*DW-1:0] prod_val;
  logic [DW-1:0]   hi_fix;
  logic [DW-1:0]   lo_fix;
  always_comb begin
    prod_mag = {hi_work_reg[DW-1:0], lo_work_reg};
    prod_val = neg_res_reg ? -prod_mag : prod_mag;
`ifdef MULDIV_MADD_EN
    if (acc_reg)
      prod_val = sub_reg ? ({hi_reg, lo_reg} - prod_val) : ({hi_reg, lo_reg} + prod_val);
`endif
    if (mult_reg) begin
      hi_fix = prod_val[2*DW-1:DW];
      lo_fix = prod_val[DW-1:0];
    end else if (div_zero_reg) begin
      // hi_work_reg was loaded with the raw dividend and left untouched
      hi_fix = hi_work_reg[DW-1:0];
      lo_fix = '1;
    end else begin
      hi_fix = neg_rem_reg ? -hi_work_reg[DW-1:0] : hi_work_reg[DW-1:0];
      lo_fix = neg_res_reg ? -lo_work_reg : lo_work_reg;
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_b_reg     <= '0;
      hi_work_reg  <= '0;
      lo_work_reg  <= '0;
      mult_reg     <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dbz_reg      <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_reg      <= 1'b0;
      sub_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg    <= CALC;
            cnt_reg      <= CW'(N - 1);
            mult_reg     <= mult_div_i;
            op_b_reg     <= mult_div_i ? mag1 : mag2;
            lo_work_reg  <= mult_div_i ? mag2 : mag1;
            hi_work_reg  <= start_dbz ? {1'b0, operand1_i} : '0;
            div_zero_reg <= start_dbz;
            neg_res_reg  <= sign_i && (operand1_i[DW-1] ^ operand2_i[DW-1]);
            neg_rem_reg  <= sign_i && operand1_i[DW-1];
            dbz_reg      <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_reg      <= acc_i;
            sub_reg      <= sub_i;
`endif
          end else begin
            if (hiw_i) hi_reg <= datain_i;
            if (low_i) lo_reg <= datain_i;
          end
        end
        CALC: begin
          if (!div_zero_reg) begin
            hi_work_reg <= hi_work_next;
            lo_work_reg <= lo_work_next;
          end
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) state_reg <= FIX;
        end
        FIX: begin
          hi_reg    <= hi_fix;
          lo_reg    <= lo_fix;
          dbz_reg   <= div_zero_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;
  assign ready_o = (state_reg == IDLE);
  assign busy_o  = !ready_o;
  assign dbz_o   = dbz_reg;

endmodule

// File: tb/tb_r2000_muldiv_iter.sv
// Testbench for r2000_muldiv_iter: vector table plus multi-cycle corner sequences.
// A BPC=4 instance shares all inputs with the BPC=1 instance.
module tb_r2000_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] operand1, operand2, datain;
  logic        sign, mult_div, start, acc, sub, hiw, low;
  logic [31:0] hi1, lo1, hi4, lo4;
  logic        ready1, busy1, dbz1, ready4, busy4, dbz4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  r2000_muldiv_iter #(.DW(32), .BPC(1)) dut (
    .clk_i(clk), .rst_i(rst_n), .operand1_i(operand1), .operand2_i(operand2),
    .sign_i(sign), .mult_div_i(mult_div), .start_i(start), .acc_i(acc), .sub_i(sub),
    .datain_i(datain), .hiw_i(hiw), .low_i(low),
    .hi_o(hi1), .lo_o(lo1), .ready_o(ready1), .busy_o(busy1), .dbz_o(dbz1)
  );

  r2000_muldiv_iter #(.DW(32), .BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .operand1_i(operand1), .operand2_i(operand2),
    .sign_i(sign), .mult_div_i(mult_div), .start_i(start), .acc_i(acc), .sub_i(sub),
    .datain_i(datain), .hiw_i(hiw), .low_i(low),
    .hi_o(hi4), .lo_o(lo4), .ready_o(ready4), .busy_o(busy4), .dbz_o(dbz4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        m;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until each instance is ready again
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic m, input logic ac, input logic sb,
                        output int lat1, output int lat4);
    int k;
    operand1 = a; operand2 = b; sign = s; mult_div = m; acc = ac; sub = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat1 = 0; lat4 = 0; k = 0;
    while ((!ready1 || !ready4) && k < 200) begin
      tick();
      k++;
      if (ready1 && lat1 == 0) lat1 = k;
      if (ready4 && lat4 == 0) lat4 = k;
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    datain = d; hiw = hw; low = lw;
    tick();
    hiw = 1'b0; low = 1'b0;
  endtask

  initial begin
    int lat1, lat4, k;

    vecs[0]  = '{32'd56,        32'd89,        1'b0, 1'b1, 32'h00000000, 32'h00001378, 1'b0};
    vecs[1]  = '{32'hFFFFFFFB,  32'h12345678,  1'b0, 1'b1, 32'h12345677, 32'hA4FA4FA8, 1'b0};
    vecs[2]  = '{32'hFFFFFFFB,  32'h12345678,  1'b1, 1'b1, 32'hFFFFFFFF, 32'hA4FA4FA8, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 1'b1, 32'h00000000, 32'h00000001, 1'b0};
    vecs[5]  = '{32'h456,       32'h23,        1'b0, 1'b0, 32'h00000019, 32'h0000001F, 1'b0};
    vecs[6]  = '{32'h456,       32'hFFFFFFFB,  1'b0, 1'b0, 32'h00000456, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h456,       32'hFFFFFFFB,  1'b1, 1'b0, 32'h00000000, 32'hFFFFFF22, 1'b0};
    vecs[8]  = '{32'hFFFFFFF9,  32'h2,         1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b0, 32'h00000000, 32'h80000000, 1'b0};
    vecs[10] = '{32'hFFFFFFF0,  32'h0,         1'b1, 1'b0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

    rst_n = 1'b0;
    operand1 = '0; operand2 = '0; datain = '0;
    sign = 1'b0; mult_div = 1'b0; start = 1'b0; acc = 1'b0; sub = 1'b0;
    hiw = 1'b0; low = 1'b0;
    repeat (2) tick();
    check("reset ready", 32'(ready1), 32'd1);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset hi", hi1, 32'h0);
    check("reset lo", lo1, 32'h0);
    check("reset dbz", 32'(dbz1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven operations on both instances
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, 1'b0, 1'b0, lat1, lat4);
      $display("vec %0d: a=%h b=%h s=%0d m=%0d -> hi=%h lo=%h dbz=%0d lat=%0d/%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, hi1, lo1, dbz1, lat1, lat4);
      check($sformatf("vec%0d hi", i), hi1, vecs[i].hi);
      check($sformatf("vec%0d lo", i), lo1, vecs[i].lo);
      check($sformatf("vec%0d dbz", i), 32'(dbz1), 32'(vecs[i].dbz));
      check($sformatf("vec%0d latency", i), 32'(lat1), 32'd33);
      check($sformatf("vec%0d bpc4 hi", i), hi4, vecs[i].hi);
      check($sformatf("vec%0d bpc4 lo", i), lo4, vecs[i].lo);
      check($sformatf("vec%0d bpc4 latency", i), 32'(lat4), 32'd9);
    end

    // Direct HI/LO writes in IDLE
    write_hilo(1'b1, 1'b0, 32'hA5A5A5A5);
    check("hiw idle hi", hi1, 32'hA5A5A5A5);
    check("hiw idle lo kept", lo1, 32'hFFFFFFFF);
    write_hilo(1'b0, 1'b1, 32'h5A5A5A5A);
    check("low idle lo", lo1, 32'h5A5A5A5A);
    check("low idle hi kept", hi1, 32'hA5A5A5A5);
    write_hilo(1'b1, 1'b1, 32'h11111111);
    check("both write hi", hi1, 32'h11111111);
    check("both write lo", lo1, 32'h11111111);

    // start_i and hiw_i pulsed mid-CALC are ignored; old HI/LO held while busy
    operand1 = 32'd56; operand2 = 32'd89; sign = 1'b0; mult_div = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy after start", 32'(busy1), 32'd1);
    tick(); tick();
    check("hold hi mid-calc", hi1, 32'h11111111);
    check("hold lo mid-calc", lo1, 32'h11111111);
    operand1 = 32'd7; operand2 = 32'd7; datain = 32'hFFFF0000; start = 1'b1; hiw = 1'b1;
    tick();
    start = 1'b0; hiw = 1'b0;
    check("hiw ignored mid-calc", hi1, 32'h11111111);
    k = 3;
    while (!ready1 && k < 200) begin
      tick();
      k++;
    end
    $display("mid-calc ignore: hi=%h lo=%h lat=%0d", hi1, lo1, k);
    check("ignore latency", 32'(k), 32'd33);
    check("ignore hi", hi1, 32'h0);
    check("ignore lo", lo1, 32'h1378);
    while (!ready4) tick();

    // Same-cycle start and hiw: start wins, the write is dropped
    write_hilo(1'b1, 1'b0, 32'hA5A5A5A5);
    operand1 = 32'd2; operand2 = 32'd3; mult_div = 1'b1; sign = 1'b0;
    datain = 32'hDEADBEEF; hiw = 1'b1; start = 1'b1;
    tick();
    hiw = 1'b0; start = 1'b0;
    check("start beats hiw", hi1, 32'hA5A5A5A5);
    k = 0;
    while ((!ready1 || !ready4) && k < 200) begin
      tick();
      k++;
    end
    check("start+hiw result hi", hi1, 32'h0);
    check("start+hiw result lo", lo1, 32'h6);

    // Divide by zero flag persists until the next start, then clears
    run_op(32'h56, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, lat1, lat4);
    check("dbz flag", 32'(dbz1), 32'd1);
    check("dbz lo", lo1, 32'hFFFFFFFF);
    check("dbz hi", hi1, 32'h56);
    check("dbz latency", 32'(lat1), 32'd33);
    tick();
    check("dbz held in idle", 32'(dbz1), 32'd1);
    operand1 = 32'h80000000; operand2 = 32'hFFFFFFFF; sign = 1'b1; mult_div = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("dbz cleared on start", 32'(dbz1), 32'd0);
    check("dbz hi held while busy", hi1, 32'h56);

    // Asynchronous reset mid-CALC
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rst mid-calc ready", 32'(ready1), 32'd1);
    check("rst mid-calc hi", hi1, 32'h0);
    check("rst mid-calc lo", lo1, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();

    // Multiply with accumulate select
    write_hilo(1'b1, 1'b1, 32'h0);
    write_hilo(1'b0, 1'b1, 32'h10);
    check("preload lo", lo1, 32'h10);
    run_op(32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 1'b0, lat1, lat4);
`ifdef MULDIV_MADD_EN
    check("madd add lo", lo1, 32'h1C);
`else
    check("madd add lo", lo1, 32'hC);
`endif
    check("madd add hi", hi1, 32'h0);
    write_hilo(1'b1, 1'b1, 32'h0);
    write_hilo(1'b0, 1'b1, 32'h10);
    run_op(32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 1'b1, lat1, lat4);
`ifdef MULDIV_MADD_EN
    check("madd sub lo", lo1, 32'h4);
`else
    check("madd sub lo", lo1, 32'hC);
`endif
    check("madd sub hi", hi1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
